// File: rtl/mag_trend_monitor.sv
// mag_trend_monitor: saturating outcome counters and alarm hysteresis FSM behind the fourbitmag comparator.
// Optional one-hot legality check and sticky err enabled by defining MAG_TREND_ONEHOT_CHK_EN.
module mag_trend_monitor #(
   parameter int THRESH = 4,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             less,
   input  logic             equal,
   input  logic             greater,
   input  logic             clr,
   output logic [1:0]       state,
   output logic             alarm,
   output logic [CNT_W-1:0] streak,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic             err
);
   typedef enum logic [1:0] {NORMAL = 2'd0, ARMING = 2'd1, ALARM = 2'd2, RELEASE = 2'd3} st_t;
   localparam logic [CNT_W-1:0] MAX = '1;
   localparam logic [CNT_W-1:0] TH  = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   st_t st;
   logic legal, g, e, l, acc, hit;
   logic [CNT_W-1:0] sp1;
`ifdef MAG_TREND_ONEHOT_CHK_EN
   assign legal = (less ^ equal ^ greater) & ~(less & equal & greater);
   assign g = greater;
   assign e = equal;
   assign l = less;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err <= 1'b0;
      else err <= ~clr & (err | (in_valid & ~legal));
`else
   // priority greater > equal > less; all-low falls through to less
   logic unused_less;
   assign unused_less = less;
   assign legal = 1'b1;
   assign g = greater;
   assign e = ~greater & equal;
   assign l = ~greater & ~equal;
   assign err = 1'b0;
`endif
   assign acc   = in_valid & ~clr & legal;
   assign sp1   = streak + ONE;
   assign hit   = sp1 == TH;
   assign state = st;
   assign alarm = st[1];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st     <= NORMAL;
         streak <= '0;
      end else if (clr) begin
         st     <= NORMAL;
         streak <= '0;
      end else if (acc)
         case (st)
            NORMAL: begin
               st     <= g ? (THRESH == 1 ? ALARM : ARMING) : NORMAL;
               streak <= (g && THRESH != 1) ? ONE : '0;
            end
            ARMING: begin
               st     <= g ? (hit ? ALARM : ARMING) : NORMAL;
               streak <= (g && !hit) ? sp1 : '0;
            end
            ALARM: begin
               st     <= g ? ALARM : (THRESH == 1 ? NORMAL : RELEASE);
               streak <= (!g && THRESH != 1) ? ONE : '0;
            end
            RELEASE: begin
               st     <= g ? ALARM : (hit ? NORMAL : RELEASE);
               streak <= (!g && !hit) ? sp1 : '0;
            end
         endcase
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         gt_cnt <= '0;
         eq_cnt <= '0;
         lt_cnt <= '0;
      end else if (clr) begin
         gt_cnt <= '0;
         eq_cnt <= '0;
         lt_cnt <= '0;
      end else if (acc) begin
         if (g && gt_cnt != MAX) gt_cnt <= gt_cnt + ONE;
         if (e && eq_cnt != MAX) eq_cnt <= eq_cnt + ONE;
         if (l && lt_cnt != MAX) lt_cnt <= lt_cnt + ONE;
      end
endmodule

// File: tb/tb_mag_trend_monitor.sv
// tb_mag_trend_monitor: randomized and directed checks of mag_trend_monitor against a run-length alarm model.
module tb_mag_trend_monitor;
   localparam int TH = 4;
   localparam int W  = 8;
   localparam int MAXC = 255;
   logic clk = 0, rst_n = 0, in_valid = 0, less = 0, equal = 0, greater = 0, clr = 0;
   logic [1:0] state;
   logic alarm, err;
   logic [W-1:0] streak, gt_cnt, eq_cnt, lt_cnt;
   int checks = 0, errors = 0;
   bit m_alarm, m_err;
   int m_run, m_gt, m_eq, m_lt;

   mag_trend_monitor #(.THRESH(TH), .CNT_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .less(less), .equal(equal),
      .greater(greater), .clr(clr), .state(state), .alarm(alarm), .streak(streak),
      .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .err(err));

   always #5 clk = ~clk;

   // alarm toggles after TH consecutive samples that argue for the opposite condition
   function automatic logic [35:0] exp_vec();
      logic [1:0] s;
      s = m_alarm ? (m_run > 0 ? 2'd3 : 2'd2) : (m_run > 0 ? 2'd1 : 2'd0);
      return {s, m_alarm, 8'(m_run), 8'(m_gt), 8'(m_eq), 8'(m_lt), m_err};
   endfunction

   function automatic logic [35:0] got_vec();
      return {state, alarm, streak, gt_cnt, eq_cnt, lt_cnt, err};
   endfunction

   task automatic model_clear();
      m_alarm = 0; m_err = 0; m_run = 0; m_gt = 0; m_eq = 0; m_lt = 0;
   endtask

   task automatic model_update(input bit v, input bit l, input bit e, input bit g, input bit c);
      bit legal, isg;
      if (c) begin
         model_clear();
         return;
      end
      if (!v) return;
`ifdef MAG_TREND_ONEHOT_CHK_EN
      legal = (int'(l) + int'(e) + int'(g)) == 1;
      if (!legal) m_err = 1;
`else
      legal = 1;
`endif
      if (!legal) return;
      isg = g;
      if (g) m_gt = (m_gt < MAXC) ? m_gt + 1 : MAXC;
      else if (e) m_eq = (m_eq < MAXC) ? m_eq + 1 : MAXC;
      else m_lt = (m_lt < MAXC) ? m_lt + 1 : MAXC;
      if (m_alarm ? !isg : isg) begin
         m_run++;
         if (m_run == TH) begin
            m_alarm = !m_alarm;
            m_run = 0;
         end
      end else m_run = 0;
   endtask

   task automatic step(input bit v, input bit l, input bit e, input bit g, input bit c);
      in_valid = v; less = l; equal = e; greater = g; clr = c;
      @(posedge clk);
      #1;
      model_update(v, l, e, g, c);
      in_valid = 0; less = 0; equal = 0; greater = 0; clr = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      model_clear();
      @(negedge clk);
      checks++;
      if (got_vec() !== 36'd0) begin
         errors++;
         $display("FAIL reset: got %h exp %h", got_vec(), 36'd0);
      end
      rst_n = 1;
   endtask

   task automatic test_alarm_entry();
      logic [1:0] exp_s [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 1, 0);
         checks++;
         if (state !== exp_s[i] || got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL entry[%0d]: got %h exp %h (state want %0d)", i, got_vec(), exp_vec(), exp_s[i]);
         end
      end
      checks++;
      if (alarm !== 1'b1 || gt_cnt !== 8'd4 || streak !== 8'd0) begin
         errors++;
         $display("FAIL entry_final: alarm %b gt %0d streak %0d exp 1 4 0", alarm, gt_cnt, streak);
      end
   endtask

   task automatic test_release();
      logic [2:0] pat [7] = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010};
      logic [1:0] exp_s [7] = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
      for (int i = 0; i < 7; i++) begin
         step(1, pat[i][2], pat[i][1], pat[i][0], 0);
         checks++;
         if (state !== exp_s[i] || got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL release[%0d]: got %h exp %h (state want %0d)", i, got_vec(), exp_vec(), exp_s[i]);
         end
      end
      checks++;
      if (alarm !== 1'b0 || eq_cnt !== 8'd5 || lt_cnt !== 8'd1) begin
         errors++;
         $display("FAIL release_final: alarm %b eq %0d lt %0d exp 0 5 1", alarm, eq_cnt, lt_cnt);
      end
   endtask

   task automatic test_gap();
      for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
      checks++;
      if (state !== 2'd1 || streak !== 8'd3) begin
         errors++;
         $display("FAIL gap_hold: state %0d streak %0d exp 1 3", state, streak);
      end
      step(1, 0, 0, 1, 0);
      checks++;
      if (state !== 2'd2 || got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL gap_alarm: got %h exp %h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_saturation();
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 300; i++) step(1, 0, 1, 0, 0);
      checks++;
      if (eq_cnt !== 8'd255 || state !== 2'd0 || got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL saturation: eq %0d state %0d exp 255 0", eq_cnt, state);
      end
   endtask

   task automatic test_clr();
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0);
      checks++;
      if (state !== 2'd1 || streak !== 8'd2) begin
         errors++;
         $display("FAIL clr_setup: state %0d streak %0d exp 1 2", state, streak);
      end
      step(1, 0, 0, 1, 1);
      checks++;
      if (got_vec() !== 36'd0) begin
         errors++;
         $display("FAIL clr: got %h exp %h", got_vec(), 36'd0);
      end
   endtask

   task automatic test_illegal();
      step(1, 0, 0, 1, 0);
      step(1, 1, 0, 1, 0);
      checks++;
`ifdef MAG_TREND_ONEHOT_CHK_EN
      if (err !== 1'b1 || gt_cnt !== 8'd1 || lt_cnt !== 8'd0 || state !== 2'd1 || streak !== 8'd1) begin
`else
      if (err !== 1'b0 || gt_cnt !== 8'd2 || lt_cnt !== 8'd0 || state !== 2'd1 || streak !== 8'd2) begin
`endif
         errors++;
         $display("FAIL illegal: got %h exp %h", got_vec(), exp_vec());
      end
      step(1, 0, 1, 0, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL illegal_sticky: got %h exp %h", got_vec(), exp_vec());
      end
      step(0, 0, 0, 0, 1);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL illegal_clr: err %b exp 0", err);
      end
   endtask

   task automatic test_async_reset();
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0);
      #2 rst_n = 0;
      model_clear();
      #1;
      checks++;
      if (got_vec() !== 36'd0) begin
         errors++;
         $display("FAIL async_reset: got %h exp %h", got_vec(), 36'd0);
      end
      @(negedge clk);
      rst_n = 1;
      step(1, 0, 0, 1, 0);
      checks++;
      if (state !== 2'd1 || streak !== 8'd1 || got_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL async_restart: got %h exp %h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      bit bias;
      int bad = 0;
      for (int i = 0; i < 1500; i++) begin
         int k;
         bit v, l, e, g, c;
         if (i % 25 == 0) bias = $urandom_range(0, 1) == 1;
         v = $urandom_range(0, 5) != 0;
         c = $urandom_range(0, 79) == 0;
         k = $urandom_range(0, 15);
         if (k < 10) begin
            g = bias ? (k < 8) : (k < 2);
            e = !g && k[0];
            l = !g && !e;
         end else begin
            {l, e, g} = 3'($urandom_range(0, 7));
         end
         step(v, l, e, g, c);
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            if (bad++ < 10) $display("FAIL random[%0d]: got %h exp %h", i, got_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_alarm_entry();
      test_release();
      test_gap();
      test_saturation();
      test_clr();
      test_illegal();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
